// File: rtl/tick_sequencer.sv
// Steps a binary or ping-pong one-hot pattern on rising edges of a selected divider level, under a start/stop FSM.
// Optional TICK_SEQ_STEP_CNT_EN adds a saturating 16-bit step counter output.
module tick_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       div_i,
  input  logic [1:0]       sel,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] pattern,
  output logic             tick_o,
  output logic             wrap_o,
  output logic             busy
`ifdef TICK_SEQ_STEP_CNT_EN
  ,
  output logic [15:0]      step_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state;
  logic [2:0]       div_s;
  logic [2:0]       div_p;
  logic             mode_l;
  logic             dir_dn;
  logic             e;
  logic [WIDTH-1:0] next_pat;
  logic             next_wrap;
  logic             next_dn;

  // div_p follows every bit continuously, so switching sel never fakes an edge
  always_comb begin
    e = 1'b1;
    case (sel)
      2'd1:    e = div_s[0] & ~div_p[0];
      2'd2:    e = div_s[1] & ~div_p[1];
      2'd3:    e = div_s[2] & ~div_p[2];
      default: e = 1'b1;
    endcase
  end

  // Ping-pong direction is decided by where the bit lands: MSB turns down, bit 0 turns up
  always_comb begin
    next_pat  = pattern + 1'b1;
    next_wrap = &pattern;
    next_dn   = dir_dn;
    if (mode_l) begin
      next_pat  = dir_dn ? (pattern >> 1) : (pattern << 1);
      next_wrap = next_pat[0];
      if (next_pat[WIDTH-1])
        next_dn = 1'b1;
      else if (next_pat[0])
        next_dn = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div_s    <= '0;
      div_p    <= '0;
      mode_l   <= 1'b0;
      dir_dn   <= 1'b0;
      pattern  <= '0;
      tick_o   <= 1'b0;
      wrap_o   <= 1'b0;
      busy     <= 1'b0;
`ifdef TICK_SEQ_STEP_CNT_EN
      step_cnt <= '0;
`endif
    end else begin
      div_s  <= div_i;
      div_p  <= div_s;
      tick_o <= 1'b0;
      wrap_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!stop && start) begin
            state   <= RUN;
            busy    <= 1'b1;
            mode_l  <= mode;
            dir_dn  <= 1'b0;
            pattern <= mode ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
`ifdef TICK_SEQ_STEP_CNT_EN
            step_cnt <= '0;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state <= PAUSE;
          end else if (e) begin
            pattern <= next_pat;
            dir_dn  <= next_dn;
            tick_o  <= 1'b1;
            wrap_o  <= next_wrap;
`ifdef TICK_SEQ_STEP_CNT_EN
            if (step_cnt != 16'hFFFF)
              step_cnt <= step_cnt + 16'd1;
`endif
          end
        end
        PAUSE: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pattern <= '0;
          end else if (start) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Randomised and directed bench for tick_sequencer against a step-index reference model.
module tb_tick_sequencer;

  localparam int W  = 8;
  localparam int PP = 2 * (W - 1);

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   div_i;
  logic [1:0]   sel;
  logic         mode;
  logic         start;
  logic         stop;
  logic [W-1:0] pattern;
  logic         tick_o;
  logic         wrap_o;
  logic         busy;
`ifdef TICK_SEQ_STEP_CNT_EN
  logic [15:0]  step_cnt;
`endif

  tick_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .div_i   (div_i),
    .sel     (sel),
    .mode    (mode),
    .start   (start),
    .stop    (stop),
    .pattern (pattern),
    .tick_o  (tick_o),
    .wrap_o  (wrap_o),
    .busy    (busy)
`ifdef TICK_SEQ_STEP_CNT_EN
    ,
    .step_cnt(step_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a step index k, plus busy/paused flags and the last two sampled divider levels
  bit       m_busy, m_paused, m_mode, m_tick, m_wrap;
  int       m_k, m_cnt, div_ctr;
  bit [2:0] h1, h2;

  function automatic logic [W-1:0] m_pat();
    int pos;
    if (!m_busy) return '0;
    if (!m_mode) return W'(m_k % (1 << W));
    pos = m_k % PP;
    if (pos > W - 1) pos = PP - pos;
    return W'(1) << pos;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_mode = 0; m_tick = 0; m_wrap = 0;
    m_k = 0; m_cnt = 0; h1 = '0; h2 = '0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input int sl, input bit md, input bit [2:0] d);
    bit ev;
    ev = (sl == 0) || (h1[sl-1] && !h2[sl-1]);
    m_tick = 0;
    m_wrap = 0;
    if (!m_busy) begin
      if (!sp && st) begin
        m_busy = 1; m_paused = 0; m_mode = md; m_k = 0; m_cnt = 0;
      end
    end else if (!m_paused) begin
      if (sp) m_paused = 1;
      else if (ev) begin
        m_k++;
        m_tick = 1;
        m_wrap = m_mode ? (m_k % PP == 0) : (m_k % (1 << W) == 0);
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      if (sp) begin m_busy = 0; m_paused = 0; m_k = 0; end
      else if (st) m_paused = 0;
    end
    h2 = h1;
    h1 = d;
  endtask

  task automatic compare_all();
    check_val("pattern", 32'(pattern), 32'(m_pat()));
    check_val("tick_o",  32'(tick_o),  32'(m_tick));
    check_val("wrap_o",  32'(wrap_o),  32'(m_wrap));
    check_val("busy",    32'(busy),    32'(m_busy));
`ifdef TICK_SEQ_STEP_CNT_EN
    check_val("step_cnt", 32'(step_cnt), 32'(m_cnt));
`endif
  endtask

  // One clk: drive at negedge, model at posedge, compare 1 time unit later
  task automatic step_clk(input bit st, input bit sp, input logic [1:0] sl, input bit md);
    @(negedge clk);
    start = st; stop = sp; sel = sl; mode = md;
    div_ctr++;
    div_i = div_ctr[2:0];
    @(posedge clk);
    model_edge(st, sp, int'(sl), md, div_i);
    #1;
    compare_all();
  endtask

  initial begin
    int ticks;
    reset = 1'b0; div_i = '0; sel = '0; mode = 1'b0; start = 1'b0; stop = 1'b0;
    div_ctr = 0;
    model_reset();
    #12;
    check_val("rst_pattern", 32'(pattern), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_tick", 32'(tick_o), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // start and stop together in IDLE: nothing happens
    repeat (3) step_clk(1, 1, 2'd0, 1'b0);
    check_val("prio_busy", 32'(busy), 32'h0);

    // fast binary count through a full wrap
    step_clk(1, 0, 2'd0, 1'b0);
    for (int i = 0; i < 256; i++) step_clk(0, 0, 2'd0, 1'b1);
    check_val("fast_wrap_pat", 32'(pattern), 32'h0);
    check_val("fast_wrap_pulse", 32'(wrap_o), 32'h1);
    step_clk(0, 0, 2'd0, 1'b0);
    check_val("fast_wrap_width", 32'(wrap_o), 32'h0);
    step_clk(0, 1, 2'd0, 1'b0);
    step_clk(0, 1, 2'd0, 1'b0);
    check_val("stop2_busy", 32'(busy), 32'h0);

    // pause at 0x05, hold, resume
    step_clk(1, 0, 2'd0, 1'b0);
    repeat (5) step_clk(0, 0, 2'd0, 1'b0);
    step_clk(0, 1, 2'd0, 1'b0);
    repeat (10) step_clk(0, 0, 2'd0, 1'b0);
    check_val("pause_hold", 32'(pattern), 32'h05);
    step_clk(1, 0, 2'd0, 1'b0);
    step_clk(0, 0, 2'd0, 1'b0);
    check_val("resume_next", 32'(pattern), 32'h06);
    step_clk(0, 1, 2'd0, 1'b0);
    step_clk(0, 1, 2'd0, 1'b0);
    check_val("idle_clear", 32'(pattern), 32'h0);

    // ping-pong: wrap on the 14th step
    step_clk(1, 0, 2'd0, 1'b1);
    for (int i = 0; i < 14; i++) step_clk(0, 0, 2'd0, 1'b0);
    check_val("pp_wrap_pat", 32'(pattern), 32'h01);
    check_val("pp_wrap_pulse", 32'(wrap_o), 32'h1);
    step_clk(0, 1, 2'd0, 1'b0);
    step_clk(0, 1, 2'd0, 1'b0);

    // divide-by-8 rate: any 64 clk window holds exactly 8 ticks
    step_clk(1, 0, 2'd3, 1'b0);
    ticks = 0;
    for (int i = 0; i < 64; i++) begin
      step_clk(0, 0, 2'd3, 1'b0);
      ticks += int'(tick_o);
    end
    check_val("div8_ticks", 32'(ticks), 32'd8);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : sel;
      step_clk($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, s, 1'($urandom));
    end

    // asynchronous reset in the middle of a run
    step_clk(1, 0, 2'd0, 1'b0);
    repeat (5) step_clk(0, 0, 2'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_pattern", 32'(pattern), 32'h0);
    check_val("arst_busy", 32'(busy), 32'h0);
    check_val("arst_tick", 32'(tick_o), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) step_clk(0, 0, 2'd0, 1'b0);
    check_val("arst_stay_idle", 32'(busy), 32'h0);
    step_clk(1, 0, 2'd0, 1'b0);
    repeat (4) step_clk(0, 0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
